// File: rtl/vfd_hmi_pkg.sv
// Shared VFD/HMI definitions: ramp FSM state encoding and the
// frequency width/clamp defaults used by setpoint, ramp and display.
package vfd_hmi_pkg;

  localparam int FREQ_W_DEF   = 10;
  localparam int FREQ_MAX_DEF = 999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_RUN   = 2'd2,
    ST_DECEL = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/ramp_tick_div.sv
// Ramp step timer: counts 1 ms ticks while enabled, fires on terminal count.
// Ports: clk/rst, tick (1 ms pulse), en, clr, tc (terminal) -> step_fire.
module ramp_tick_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] tc,
  output logic       step_fire
);

  logic [7:0] cnt;

  assign step_fire = en & tick & (cnt == tc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || step_fire) begin
      cnt <= '0;
    end else if (en && tick) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/freq_ramp_ctrl.sv
// Soft-start/soft-stop sequencer slewing freq_out toward the clamped setpoint.
// Ports: clk_sys, rst, pluse_ms, run, freq_set -> freq_out, at_speed, ramping,
// state. Macro FREQ_RAMP_ESTOP_EN adds the estop input and restart lockout.
module freq_ramp_ctrl
  import vfd_hmi_pkg::*;
#(
  parameter int FREQ_W   = FREQ_W_DEF,
  parameter int FREQ_MAX = FREQ_MAX_DEF,
  parameter int ACC_MS   = 10,
  parameter int DEC_MS   = 20,
  parameter int STEP     = 1
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_ms,
  input  logic              run,
`ifdef FREQ_RAMP_ESTOP_EN
  input  logic              estop,
`endif
  input  logic [FREQ_W-1:0] freq_set,
  output logic [FREQ_W-1:0] freq_out,
  output logic              at_speed,
  output logic              ramping,
  output logic [1:0]        state
);

  localparam logic [FREQ_W-1:0] FMAX   = FREQ_W'(FREQ_MAX);
  localparam logic [FREQ_W:0]   STEP_X = (FREQ_W+1)'(STEP);
  localparam logic [7:0]        ACC_TC = 8'(ACC_MS - 1);
  localparam logic [7:0]        DEC_TC = 8'(DEC_MS - 1);

  ramp_state_e       st, st_n;
  logic [FREQ_W-1:0] freq_n, target;
  logic [FREQ_W-1:0] up_sat, dn_sat;
  logic [FREQ_W:0]   up, dn;
  logic              run_ok, kill;
  logic              step_fire, clr, cnt_en;
  logic [7:0]        tc;

`ifdef FREQ_RAMP_ESTOP_EN
  // Set by estop, released only once run is seen low.
  logic lock;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      lock <= 1'b0;
    end else if (estop) begin
      lock <= 1'b1;
    end else if (!run) begin
      lock <= 1'b0;
    end
  end

  assign kill   = estop;
  assign run_ok = run & ~lock & ~estop;
`else
  assign kill   = 1'b0;
  assign run_ok = run;
`endif

  assign target = !run_ok ? '0 :
                  (freq_set > FMAX) ? FMAX : freq_set;

  // One spare bit so neither direction can wrap; a borrow means
  // the step passed zero, which is always below target.
  assign up     = {1'b0, freq_out} + STEP_X;
  assign dn     = {1'b0, freq_out} - STEP_X;
  assign up_sat = (up > {1'b0, target}) ? target : up[FREQ_W-1:0];
  assign dn_sat = (dn[FREQ_W] || (dn[FREQ_W-1:0] < target)) ?
                  target : dn[FREQ_W-1:0];

  assign cnt_en = (st == ST_ACCEL) || (st == ST_DECEL);
  assign tc     = (st == ST_DECEL) ? DEC_TC : ACC_TC;
  assign clr    = kill || (st_n != st);

  ramp_tick_div u_tick (
    .clk       (clk_sys),
    .rst       (rst),
    .tick      (pluse_ms),
    .en        (cnt_en),
    .clr       (clr),
    .tc        (tc),
    .step_fire (step_fire)
  );

  always_comb begin
    st_n   = st;
    freq_n = freq_out;
    unique case (st)
      ST_IDLE: begin
        freq_n = '0;
        if (target > freq_out) st_n = ST_ACCEL;
      end
      ST_ACCEL: begin
        if (freq_out == target)     st_n = ST_RUN;
        else if (target < freq_out) st_n = ST_DECEL;
        else if (step_fire)         freq_n = up_sat;
      end
      ST_RUN: begin
        if (target > freq_out)      st_n = ST_ACCEL;
        else if (target < freq_out) st_n = ST_DECEL;
      end
      ST_DECEL: begin
        if (freq_out == target)
          st_n = (target == '0) ? ST_IDLE : ST_RUN;
        else if (target > freq_out) st_n = ST_ACCEL;
        else if (step_fire)         freq_n = dn_sat;
      end
    endcase
    if (kill) begin
      st_n   = ST_IDLE;
      freq_n = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      freq_out <= '0;
      at_speed <= 1'b0;
      ramping  <= 1'b0;
    end else begin
      st       <= st_n;
      freq_out <= freq_n;
      at_speed <= (st_n == ST_RUN) && (freq_n == target);
      ramping  <= (st_n == ST_ACCEL) || (st_n == ST_DECEL);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Directed bench for freq_ramp_ctrl: soft start, clamp, reversal, stop,
// async reset mid-ramp and (with FREQ_RAMP_ESTOP_EN) estop lockout.
module tb_freq_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pluse_ms;
  logic       run_a, run_b;
  logic [9:0] set_a, set_b;
  logic [9:0] freq_a, freq_b;
  logic       spd_a, spd_b, rmp_a, rmp_b;
  logic [1:0] st_a, st_b;
`ifdef FREQ_RAMP_ESTOP_EN
  logic       estop_a, estop_b;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  freq_ramp_ctrl #(
    .FREQ_W(10), .FREQ_MAX(999), .ACC_MS(2), .DEC_MS(3), .STEP(1)
  ) u_a (
    .clk_sys  (clk),
    .rst      (rst),
    .pluse_ms (pluse_ms),
    .run      (run_a),
`ifdef FREQ_RAMP_ESTOP_EN
    .estop    (estop_a),
`endif
    .freq_set (set_a),
    .freq_out (freq_a),
    .at_speed (spd_a),
    .ramping  (rmp_a),
    .state    (st_a)
  );

  freq_ramp_ctrl #(
    .FREQ_W(10), .FREQ_MAX(999), .ACC_MS(1), .DEC_MS(1), .STEP(7)
  ) u_b (
    .clk_sys  (clk),
    .rst      (rst),
    .pluse_ms (pluse_ms),
    .run      (run_b),
`ifdef FREQ_RAMP_ESTOP_EN
    .estop    (estop_b),
`endif
    .freq_set (set_b),
    .freq_out (freq_b),
    .at_speed (spd_b),
    .ramping  (rmp_b),
    .state    (st_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 1 ms pulse edge followed by one quiet edge.
  task automatic ms();
    pluse_ms = 1'b1;
    cyc(1);
    pluse_ms = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst      = 1'b1;
    pluse_ms = 1'b0;
    run_a    = 1'b0;
    run_b    = 1'b0;
    set_a    = '0;
    set_b    = '0;
`ifdef FREQ_RAMP_ESTOP_EN
    estop_a  = 1'b0;
    estop_b  = 1'b0;
`endif
    #12;
    chk("rst_freq", freq_a, 0);
    chk("rst_state", st_a, 0);
    chk("rst_spd", spd_a, 0);
    chk("rst_rmp", rmp_a, 0);
    cyc(1);
    rst = 1'b0;

    // soft start 0 -> 5, ACC_MS=2
    run_a = 1'b1;
    set_a = 10'd5;
    cyc(1);
    chk("ss_accel", st_a, 1);
    chk("ss_rmp", rmp_a, 1);
    ms();
    chk("ss_first_pulse", freq_a, 0);
    ms();
    chk("ss_step1", freq_a, 1);
    repeat (7) ms();
    chk("ss_f4", freq_a, 4);
    pluse_ms = 1'b1;
    cyc(1);
    pluse_ms = 1'b0;
    chk("ss_f5", freq_a, 5);
    chk("ss_spd_lag", spd_a, 0);
    chk("ss_st_lag", st_a, 1);
    cyc(1);
    chk("ss_run", st_a, 2);
    chk("ss_spd", spd_a, 1);
    chk("ss_rmp_off", rmp_a, 0);

    // reversal: up toward 50, turn back at 30 toward 10
    set_a = 10'd50;
    cyc(1);
    chk("rv_accel", st_a, 1);
    repeat (50) ms();
    chk("rv_f30", freq_a, 30);
    set_a = 10'd10;
    cyc(1);
    chk("rv_decel", st_a, 3);
    chk("rv_nostep", freq_a, 30);
    repeat (2) ms();
    chk("rv_hold", freq_a, 30);
    ms();
    chk("rv_dn1", freq_a, 29);
    repeat (57) ms();
    chk("rv_f10", freq_a, 10);
    chk("rv_run", st_a, 2);
    chk("rv_spd", spd_a, 1);

    // stop ramp to zero
    run_a = 1'b0;
    cyc(1);
    chk("sp_decel", st_a, 3);
    chk("sp_spd", spd_a, 0);
    repeat (30) ms();
    chk("sp_f0", freq_a, 0);
    chk("sp_idle", st_a, 0);
    chk("sp_spd0", spd_a, 0);
    chk("sp_rmp0", rmp_a, 0);

    // clamp / overshoot with STEP=7
    run_b = 1'b1;
    set_b = 10'd20;
    cyc(1);
    chk("cl_accel", st_b, 1);
    ms();
    chk("cl_f7", freq_b, 7);
    ms();
    chk("cl_f14", freq_b, 14);
    ms();
    chk("cl_f20", freq_b, 20);
    chk("cl_run", st_b, 2);
    ms();
    chk("cl_hold20", freq_b, 20);
    set_b = 10'd1023;
    cyc(1);
    chk("cl_accel2", st_b, 1);
    repeat (140) ms();
    chk("cl_f999", freq_b, 999);
    chk("cl_run999", st_b, 2);
    ms();
    chk("cl_hold999", freq_b, 999);

    // down to 1, then stop: no underflow
    set_b = 10'd1;
    cyc(1);
    chk("uf_decel", st_b, 3);
    repeat (143) ms();
    chk("uf_f1", freq_b, 1);
    chk("uf_run", st_b, 2);
    run_b = 1'b0;
    cyc(1);
    ms();
    chk("uf_f0", freq_b, 0);
    chk("uf_idle", st_b, 0);

    // async reset mid-ramp
    run_a = 1'b1;
    set_a = 10'd200;
    cyc(1);
    repeat (246) ms();
    chk("rm_f123", freq_a, 123);
    #3 rst = 1'b1;
    #1;
    chk("rm_f0", freq_a, 0);
    chk("rm_idle", st_a, 0);
    chk("rm_rmp", rmp_a, 0);
    #2 rst = 1'b0;
    cyc(1);
    chk("rm_accel", st_a, 1);
    ms();
    chk("rm_wait", freq_a, 0);
    ms();
    chk("rm_step", freq_a, 1);

`ifdef FREQ_RAMP_ESTOP_EN
    run_b = 1'b1;
    set_b = 10'd203;
    cyc(1);
    repeat (29) ms();
    chk("es_f203", freq_b, 203);
    estop_b = 1'b1;
    cyc(1);
    chk("es_f0", freq_b, 0);
    chk("es_idle", st_b, 0);
    cyc(2);
    estop_b = 1'b0;
    cyc(2);
    repeat (3) ms();
    chk("es_lock_f", freq_b, 0);
    chk("es_lock_st", st_b, 0);
    run_b = 1'b0;
    cyc(1);
    run_b = 1'b1;
    cyc(1);
    chk("es_rearm", st_b, 1);
    ms();
    chk("es_f7", freq_b, 7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_ramp_ctrl.md
Name: freq_ramp_ctrl

Overview:
- Soft-start/soft-stop sequencer for the VFD output frequency.
- Takes the operator setpoint from the HMI frequency generator (0..999 Hz, 10-bit) and a run command, and slews the drive frequency toward the target at programmed accel/decel rates.
- Steps are timed by the existing 1 ms pulse.
- Sits between the HMI setpoint logic and the PWM/waveform datapath; its output also feeds the BCD/7-seg display path.

Parameters:
- FREQ_W, 10, width of setpoint and output frequency
- FREQ_MAX, 999, setpoint clamp (Hz)
- ACC_MS, 10, ms ticks per upward step (1..255)
- DEC_MS, 20, ms ticks per downward step (1..255)
- STEP, 1, Hz per step (1..FREQ_MAX)

Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- pluse_ms  in  1  one-clk_sys-wide pulse every 1 ms
- run  in  1  level; 1 = drive enabled, 0 = stop request
- freq_set  in  FREQ_W  operator setpoint, sampled every cycle
- freq_out  out  FREQ_W  current commanded frequency (registered)
- at_speed  out  1  freq_out == target and state RUN
- ramping  out  1  state is ACCEL or DECEL
- state  out  2  0 IDLE, 1 ACCEL, 2 RUN, 3 DECEL

Behaviour:
- Reset values (asynchronous, while rst=1): freq_out=0, state=IDLE, at_speed=0, ramping=0, tick counter=0. Reset mid-ramp aborts immediately to these values; no ramp-down.
- target (combinational) = run ? min(freq_set, FREQ_MAX) : 0.
- Tick counter:
  - 8-bit; increments on pluse_ms.
  - On reaching (ACC_MS-1) in ACCEL or (DEC_MS-1) in DECEL, a step fires on that same pluse_ms cycle and the counter clears.
  - The counter clears on every state change.
  - The counter holds (no increment) in IDLE and RUN.
- Step:
  - ACCEL: freq_out <= min(freq_out+STEP, target).
  - DECEL: freq_out <= max(freq_out-STEP, target), saturating at 0.
  - No overshoot and no wrap. Arithmetic is done FREQ_W+1 bits wide.
- FSM, evaluated every clk_sys; the transition takes effect on the next edge:
  - IDLE: target>freq_out -> ACCEL; else stay. freq_out is held at 0.
  - ACCEL: freq_out==target -> RUN; target<freq_out -> DECEL (reversal mid-ramp, counter clears, no step that cycle).
  - RUN: target>freq_out -> ACCEL; target<freq_out -> DECEL.
  - DECEL: freq_out==target and target==0 -> IDLE; freq_out==target and target!=0 -> RUN; target>freq_out -> ACCEL.
- Simultaneous events: if a step fires and the target changes in the same cycle, the step uses the current-cycle target (clamp applies), then FSM re-evaluates next cycle.
- run drop while in ACCEL: switch to DECEL toward 0 with no further upward step.
- Outputs at_speed and ramping are registered and decode the next-state, so they align with state.
- Latency: first step occurs ACC_MS pluse_ms pulses after entry to ACCEL. Full-scale 0->999 with defaults takes 9990 ms.
- freq_out changes only on pluse_ms cycles, except at reset.

Optional Feature:
- Macro FREQ_RAMP_ESTOP_EN.
- With the macro defined:
  - Extra input estop (1 bit, level).
  - While estop=1: freq_out forced to 0 on the next clk_sys edge, state=IDLE, counter cleared; run is ignored.
  - After estop deasserts, a restart requires run to go 0 then 1 (a latched flag, cleared on reset).
- Without the macro: no port, no logic; stop is always a DECEL ramp.

Decomposition:
- Package vfd_hmi_pkg:
  - state encoding constants ST_IDLE/ST_ACCEL/ST_RUN/ST_DECEL.
  - FREQ_W and FREQ_MAX defaults, shared with the frequency generator and display path.
- One sub-module: ramp_tick_div.
  - Holds the 8-bit pluse_ms counter with clear and terminal-count inputs.
  - Outputs step_fire.
- Clamp/step arithmetic and the FSM stay in freq_ramp_ctrl.

Test Plan:
- Soft start: ACC_MS=2, STEP=1, run=1, freq_set=5 -> freq_out rises by 1 every 2 pluse_ms; at_speed=1 one cycle after freq_out=5; state sequence IDLE->ACCEL->RUN.
- Clamp and overshoot: STEP=7, freq_set=20 -> freq_out 0,7,14,20 (never 21); freq_set=1023 -> ramps to 999, not beyond.
- Reversal: ramping up at freq_out=30 toward 50, setpoint changes to 10 -> state DECEL on the next cycle; freq_out decrements at the DEC_MS rate to 10, then RUN.
- Stop: in RUN at 40, run=0 -> DECEL, freq_out reaches 0, state IDLE, at_speed=0; no underflow at 0 with STEP=3 from freq_out=1.
- Reset mid-ramp: assert rst asynchronously (not clock-aligned) at freq_out=123 -> freq_out=0 and state IDLE immediately; after release, waits for pluse_ms before the first step.
- FREQ_RAMP_ESTOP_EN build: estop=1 at freq_out=200 -> freq_out=0 next edge; after estop drops with run still 1, freq_out stays 0 until run toggles 0->1.
